ez8_prog_loader: RTL
====================

// Module: ez8_prog_loader
// PURPOSE
//   Upstream loader for ez8_cpu. Receives a framed program as a byte stream (valid/ready),
//   assembles 16-bit instruction words and writes them through the CPU's instr_write port.
//   Holds the CPU paused and in reset while loading; on a verified frame, releases it to run.
// PARAMETERS
//   ADDR_WIDTH    12     instruction memory address width; max words = 2**ADDR_WIDTH
//   SYNC_BYTE     8'hA5  frame start marker
//   RESET_CYCLES  1      cycles cpu_reset held high with cpu_pause low before run (>=1)
// PORTS
//   clk              in   1           system clock
//   reset            in   1           synchronous, active-high
//   in_data          in   8           stream byte
//   in_valid         in   1           in_data valid
//   in_ready         out  1           byte accepted on cycle with in_valid & in_ready
//   instr_writeaddr  out  ADDR_WIDTH  to ez8_cpu instr_writeaddr
//   instr_writedata  out  16          to ez8_cpu instr_writedata
//   instr_write_en   out  1           to ez8_cpu instr_write_en, one-cycle pulse per word
//   cpu_pause        out  1           to ez8_cpu pause
//   cpu_reset        out  1           to ez8_cpu reset
//   done             out  1           high while CPU released (RUN)
//   load_error       out  1           sticky; last frame rejected
// BEHAVIOUR
//   Frame: SYNC, LEN_HI, LEN_LO, {W_HI, W_LO} x LEN, CKSUM. CKSUM = 8-bit sum mod 256 of
//   LEN_HI, LEN_LO and all word bytes (SYNC excluded). Words high byte first.
//   Reset values: state IDLE, in_ready 0 for the reset cycle then per state, instr_writeaddr 0,
//   instr_writedata 0, instr_write_en 0, cpu_pause 1, cpu_reset 1, done 0, load_error 0.
//   States (all transitions on accepted byte unless noted):
//     IDLE     in_ready 1; SYNC -> LEN_HI, clear load_error; other bytes dropped.
//     LEN_HI   store; -> LEN_LO.
//     LEN_LO   LEN > 2**ADDR_WIDTH -> IDLE, load_error 1, no writes;
//              LEN == 0 -> CHECK; else -> DATA_HI. Word counter and addr cleared to 0.
//     DATA_HI  latch high byte; -> DATA_LO.
//     DATA_LO  next cycle: instr_writedata = {hi,lo}, instr_write_en = 1 for exactly one cycle
//              at current addr; addr increments after the pulse. Last word -> CHECK else DATA_HI.
//              in_ready stays 1; a byte accepted during the write cycle is processed normally.
//     CHECK    match -> RESET_CPU; mismatch -> IDLE, load_error 1 (memory left as written).
//     RESET_CPU in_ready 0; cpu_pause 0, cpu_reset 1 for RESET_CYCLES cycles -> RUN (no byte).
//     RUN      cpu_pause 0, cpu_reset 0, done 1; in_ready 1; SYNC -> LEN_HI (next cycle:
//              cpu_pause 1, cpu_reset 1, done 0, load_error cleared); other bytes dropped.
//   cpu_pause = 1 and cpu_reset = 1 in every state except RESET_CPU (pause 0) and RUN (both 0).
//   in_valid low cycles (bubbles) anywhere: state holds, no side effects.
//   instr_writeaddr never wraps (LEN bounded); after a full 2**ADDR_WIDTH load it is not used
//   again until cleared in LEN_LO. All outputs registered.
//   reset mid-frame: immediate return to reset values; partially written memory not cleared.
// TESTING
//   1. A5 00 03 12 34 56 78 9A BC 6D -> writes (0,1234),(1,5678),(2,9ABC), one pulse each;
//      then 1 cycle cpu_reset=1/cpu_pause=0; then RUN: done=1, cpu_reset=0, cpu_pause=0.
//   2. Same frame, CKSUM 6E -> three writes occur, load_error=1, IDLE, cpu_pause=1, done=0.
//   3. A5 10 01 -> load_error=1 right after LEN_LO, no instr_write_en pulse, IDLE.
//   4. Bytes 00 FF 13 before A5, random in_valid gaps inside case 1 -> identical writes/outcome.
//   5. In RUN send A5 00 00 00 -> pause/reset reassert next cycle, done=0, no writes, re-RUN.
//   6. reset asserted after 2nd word of case 1 -> reset values; new case-1 frame writes from 0.

Source files
------------

// File: rtl/ez8_prog_loader.sv
// Framed byte-stream program loader for ez8_cpu: assembles 16-bit words, writes instruction
// memory, verifies the checksum, then sequences the CPU out of pause/reset.
//
// state     | meaning
// IDLE      | waiting for SYNC, CPU held
// LEN_HI    | expecting length high byte
// LEN_LO    | expecting length low byte, range check
// DATA_HI   | expecting word high byte
// DATA_LO   | expecting word low byte, write issued next cycle
// CHECK     | expecting checksum byte
// RESET_CPU | CPU unpaused but still in reset
// RUN       | CPU running, SYNC restarts a load
module ez8_prog_loader #(
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          RESET_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] instr_writeaddr,
  output logic [15:0]           instr_writedata,
  output logic                  instr_write_en,
  output logic                  cpu_pause,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  load_error
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;
  localparam int          RC_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RESET_CPU, RUN
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            len_hi;
  logic [7:0]            word_hi;
  logic [7:0]            sum;
  logic [ADDR_WIDTH:0]   words_left;
  logic [RC_W-1:0]       rst_cnt;

  logic                  accept;
  logic                  is_sync;
  logic [15:0]           len_full;
  logic                  too_big;
  logic                  last_word;
  logic                  cksum_ok;

  assign accept    = in_valid & in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign len_full  = {len_hi, in_data};
  assign too_big   = ({1'b0, len_full} > MAX_WORDS);
  assign last_word = (words_left == (ADDR_WIDTH + 1)'(1));
  assign cksum_ok  = (in_data == sum);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept && is_sync) state_nxt = LEN_HI;
      LEN_HI:    if (accept) state_nxt = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (too_big)               state_nxt = IDLE;
          else if (len_full == 16'd0) state_nxt = CHECK;
          else                       state_nxt = DATA_HI;
        end
      end
      DATA_HI:   if (accept) state_nxt = DATA_LO;
      DATA_LO:   if (accept) state_nxt = last_word ? CHECK : DATA_HI;
      CHECK:     if (accept) state_nxt = cksum_ok ? RESET_CPU : IDLE;
      RESET_CPU: if (rst_cnt == RC_W'(1)) state_nxt = RUN;
      RUN:       if (accept && is_sync) state_nxt = LEN_HI;
      default:   state_nxt = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      in_ready        <= 1'b0;
      instr_writeaddr <= '0;
      instr_writedata <= '0;
      instr_write_en  <= 1'b0;
      cpu_pause       <= 1'b1;
      cpu_reset       <= 1'b1;
      done            <= 1'b0;
      load_error      <= 1'b0;
      len_hi          <= '0;
      word_hi         <= '0;
      sum             <= '0;
      words_left      <= '0;
      rst_cnt         <= '0;
    end else begin
      state          <= state_nxt;
      in_ready       <= (state_nxt != RESET_CPU);
      cpu_pause      <= !((state_nxt == RESET_CPU) || (state_nxt == RUN));
      cpu_reset      <= (state_nxt != RUN);
      done           <= (state_nxt == RUN);
      instr_write_en <= 1'b0;

      // Saturate so a full-depth load never wraps back onto word 0.
      if (instr_write_en && (instr_writeaddr != '1))
        instr_writeaddr <= instr_writeaddr + 1'b1;

      if (state == RESET_CPU)
        rst_cnt <= rst_cnt - 1'b1;

      if (accept) begin
        case (state)
          IDLE, RUN: begin
            if (is_sync) begin
              sum        <= '0;
              load_error <= 1'b0;
            end
          end
          LEN_HI: begin
            len_hi <= in_data;
            sum    <= sum + in_data;
          end
          LEN_LO: begin
            sum             <= sum + in_data;
            words_left      <= len_full[ADDR_WIDTH:0];
            instr_writeaddr <= '0;
            if (too_big) load_error <= 1'b1;
          end
          DATA_HI: begin
            word_hi <= in_data;
            sum     <= sum + in_data;
          end
          DATA_LO: begin
            instr_writedata <= {word_hi, in_data};
            instr_write_en  <= 1'b1;
            sum             <= sum + in_data;
            words_left      <= words_left - 1'b1;
          end
          CHECK: begin
            if (cksum_ok) rst_cnt    <= RC_W'(RESET_CYCLES);
            else          load_error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
